// File: rtl/mic_decimator.sv
// Block-average decimator: sums N = 2**LOG2_N valid samples and presents the
// truncated mean on a valid/ready output, flagging overwritten results.
module mic_decimator #(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned LOG2_N  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  input  logic               din_valid,
  input  logic               dout_ready,
  output logic [D_WIDTH-1:0] dout,
  output logic               dout_valid,
  output logic               overrun
);

  localparam int unsigned AW = D_WIDTH + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [LOG2_N-1:0]  cnt_q, cnt_d;
  logic [D_WIDTH-1:0] dout_q, dout_d;
  logic               ovr_q, ovr_d;

  logic [AW-1:0]      sum;
  logic [D_WIDTH-1:0] avg;
  logic               complete;

  assign sum      = acc_q + {{LOG2_N{1'b0}}, din};
  assign avg      = sum[AW-1:LOG2_N];
  assign complete = din_valid && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (en) state_d = ACCUM;
      end
      ACCUM, HOLD: begin
        if (!en) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (complete) begin
          // A completion wins over a simultaneous transfer: the new result
          // stays valid, and only an untaken result counts as overrun.
          dout_d  = avg;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = HOLD;
          if ((state_q == HOLD) && !dout_ready) ovr_d = 1'b1;
        end else begin
          if (din_valid) begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
          end
          if ((state_q == HOLD) && dout_ready) state_d = ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == HOLD);
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_mic_decimator.sv
// Directed vector bench for mic_decimator (D_WIDTH=8, LOG2_N=2): each record
// gives inputs for one clock and the outputs expected after that edge.
module tb_mic_decimator;

  logic       clk = 1'b0;
  logic       rst, en, din_valid, dout_ready;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid, overrun;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  mic_decimator #(.D_WIDTH(8), .LOG2_N(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .din_valid (din_valid),
    .dout_ready(dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic       dv;
    logic       rdy;
    logic [7:0] e_dout;
    logic       e_valid;
    logic       e_ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input logic r, input logic e, input logic [7:0] d,
                            input logic dv, input logic rdy, input logic [7:0] ed,
                            input logic ev, input logic eo);
    vec_t t;
    t.rst = r; t.en = e; t.din = d; t.dv = dv; t.rdy = rdy;
    t.e_dout = ed; t.e_valid = ev; t.e_ovr = eo;
    tbl.push_back(t);
  endfunction

  task automatic drive(input logic r, input logic e, input logic [7:0] d,
                       input logic dv, input logic rdy);
    rst = r; en = e; din = d; din_valid = dv; dout_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] ed, input logic ev,
                       input logic eo);
    nvec++;
    if (dout !== ed || dout_valid !== ev || overrun !== eo) begin
      nmis++;
      $display("FAIL %s: got dout=%0d valid=%0b overrun=%0b, want dout=%0d valid=%0b overrun=%0b",
               name, dout, dout_valid, overrun, ed, ev, eo);
    end
  endtask

  initial begin
    // reset and hold
    v(1,0,  0,0,0,   0,0,0);
    v(1,1,  5,1,1,   0,0,0);
    // IDLE ignores din even with en=1
    v(0,1, 99,1,1,   0,0,0);
    // 10,20,30,41 -> 25 for exactly one cycle
    v(0,1, 10,1,1,   0,0,0);
    v(0,1, 20,1,1,   0,0,0);
    v(0,1, 30,1,1,   0,0,0);
    v(0,1, 41,1,1,  25,1,0);
    v(0,1,  0,0,1,  25,0,0);
    v(0,1,  0,0,1,  25,0,0);
    // all-max with valid gaps
    v(0,1,255,1,1,  25,0,0);
    v(0,1,  0,0,1,  25,0,0);
    v(0,1,255,1,1,  25,0,0);
    v(0,1,  0,0,1,  25,0,0);
    v(0,1,255,1,1,  25,0,0);
    v(0,1,255,1,1, 255,1,0);
    v(0,1,  0,0,1, 255,0,0);
    // ready low: 4s then 8s -> overrun
    v(0,1,  4,1,0, 255,0,0);
    v(0,1,  4,1,0, 255,0,0);
    v(0,1,  4,1,0, 255,0,0);
    v(0,1,  4,1,0,   4,1,0);
    v(0,1,  8,1,0,   4,1,0);
    v(0,1,  8,1,0,   4,1,0);
    v(0,1,  8,1,0,   4,1,0);
    v(0,1,  8,1,0,   8,1,1);
    v(0,1,  0,0,0,   8,1,1);
    v(0,1,  0,0,1,   8,0,1);
    v(0,1,  0,0,1,   8,0,1);
    // completion on the transfer cycle: no overrun
    v(1,1,  0,0,0,   0,0,0);
    v(0,1,  0,0,0,   0,0,0);
    v(0,1,  4,1,0,   0,0,0);
    v(0,1,  4,1,0,   0,0,0);
    v(0,1,  4,1,0,   0,0,0);
    v(0,1,  4,1,0,   4,1,0);
    v(0,1,  8,1,0,   4,1,0);
    v(0,1,  8,1,0,   4,1,0);
    v(0,1,  8,1,0,   4,1,0);
    v(0,1,  8,1,1,   8,1,0);
    v(0,1,  0,0,1,   8,0,0);
    // en drop discards a partial sum
    v(0,1, 50,1,1,   8,0,0);
    v(0,1, 60,1,1,   8,0,0);
    v(0,0, 70,1,1,   8,0,0);
    v(0,1, 70,1,1,   8,0,0);
    v(0,1,100,1,1,   8,0,0);
    v(0,1,100,1,1,   8,0,0);
    v(0,1,100,1,1,   8,0,0);
    v(0,1,100,1,1, 100,1,0);
    // en drop in HOLD discards pending result, dout retained
    v(0,0,  0,0,0, 100,0,0);
    v(0,1,  0,0,0, 100,0,0);
    // rst during HOLD with overrun set
    v(0,1,  1,1,0, 100,0,0);
    v(0,1,  1,1,0, 100,0,0);
    v(0,1,  1,1,0, 100,0,0);
    v(0,1,  1,1,0,   1,1,0);
    v(0,1,  3,1,0,   1,1,0);
    v(0,1,  3,1,0,   1,1,0);
    v(0,1,  3,1,0,   1,1,0);
    v(0,1,  3,1,0,   3,1,1);
    v(1,1,200,1,1,   0,0,0);
    v(0,1,  7,1,1,   0,0,0);
    // truncation: 1+2+3+5 = 11 -> 2
    v(0,1,  1,1,1,   0,0,0);
    v(0,1,  2,1,1,   0,0,0);
    v(0,1,  3,1,1,   0,0,0);
    v(0,1,  5,1,1,   2,1,0);
    v(0,1,  0,0,1,   2,0,0);

    rst = 1'b1; en = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].din, tbl[i].dv, tbl[i].rdy);
      check($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_valid, tbl[i].e_ovr);
    end

    // Latency: valid must appear right after the 4th back-to-back sample.
    begin
      int unsigned waited;
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 8'd200, 1, 0);
      check("latency_4th", 8'd200, 1'b1, 1'b0);
      // hold stable while not taken, then a bounded wait for the transfer
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
      check("hold_stable", 8'd200, 1'b1, 1'b0);
      waited = 0;
      dout_ready = 1'b1;
      while (dout_valid === 1'b1 && waited < 5) begin
        @(posedge clk);
        #1;
        waited++;
      end
      nvec++;
      if (waited != 1) begin
        nmis++;
        $display("FAIL xfer_cycles: took %0d cycles, want 1", waited);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mic_decimator.md
MIC_DECIMATOR -- requirements
Module: mic_decimator

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 8, giving sample width for input and output.
REQ-002 The block SHALL have parameter LOG2_N, default 2, where N = 2**LOG2_N is the number of input samples per output sample.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  block enable; low forces IDLE.
REQ-006 din  input  D_WIDTH  raw unsigned mic sample.
REQ-007 din_valid  input  1  din valid this cycle.
REQ-008 dout_ready  input  1  downstream delay stage can take dout this cycle.
REQ-009 dout  output  D_WIDTH  decimated (averaged) sample.
REQ-010 dout_valid  output  1  dout holds an untaken result; drives downstream write enable.
REQ-011 overrun  output  1  sticky flag: an untaken result was overwritten.
REQ-012 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst.

Function
REQ-013 The block SHALL hold states IDLE, ACCUM and HOLD, an accumulator acc of D_WIDTH+LOG2_N bits, and a sample counter cnt of LOG2_N bits.
REQ-014 IDLE: acc=0 and cnt=0; en=1 -> ACCUM next cycle; din ignored while in IDLE.
REQ-015 ACCUM/HOLD, din_valid=1: acc <= acc+din and cnt <= cnt+1 (mod N); din_valid=0: acc and cnt hold.
REQ-016 Block completion = din_valid=1 with cnt=N-1; next cycle dout = (acc+din) >> LOG2_N (truncating), dout_valid=1, acc=0, cnt=0, state HOLD.
REQ-017 Latency: result visible exactly one cycle after the Nth accepted sample.
REQ-018 Sum width D_WIDTH+LOG2_N SHALL never overflow; all-max input SHALL give dout = 2**D_WIDTH-1.
REQ-019 Handshake: transfer occurs on a cycle with dout_valid=1 and dout_ready=1; dout_valid=0 next cycle, state ACCUM.
REQ-020 dout and dout_valid SHALL stay stable in HOLD until transfer, except as in REQ-021.
REQ-021 Completion in HOLD with no transfer that cycle: dout overwritten with new result, dout_valid stays 1, overrun <= 1.
REQ-022 Completion on the same cycle as a transfer: dout takes new result, dout_valid stays 1, state stays HOLD, overrun unchanged.
REQ-023 Accumulation SHALL continue during HOLD; no input sample is dropped.
REQ-024 dout_ready while dout_valid=0 SHALL have no effect.
REQ-025 en=0 in ACCUM or HOLD: next cycle IDLE, acc=0, cnt=0, dout_valid=0; dout and overrun retain their values; pending result discarded.
REQ-026 overrun, once set, SHALL clear only on rst.

Reset
REQ-027 rst=1 at a clock edge SHALL set state IDLE, acc=0, cnt=0, dout=0, dout_valid=0, overrun=0, overriding all other inputs.
REQ-028 Reset mid-block or mid-HOLD SHALL discard partial sums and pending results; first block after reset starts from cnt=0.
REQ-029 Outputs SHALL reach reset values on the first edge with rst=1 and hold them while rst=1.

Verification (D_WIDTH=8, LOG2_N=2)
REQ-030 en=1, dout_ready=1, din 10,20,30,41 on 4 consecutive valid cycles -> dout=25, dout_valid=1 for exactly one cycle, one cycle after 41.
REQ-031 Four samples of 255 -> dout=255; din_valid gaps between samples -> same result, emitted one cycle after the 4th valid sample.
REQ-032 dout_ready=0, block 4,4,4,4 then block 8,8,8,8 -> dout 4 then 8, dout_valid held high, overrun=1 after second completion, stays 1 until rst.
REQ-033 dout_ready=1 on the same cycle the second block completes -> dout=8, dout_valid continuous, overrun=0.
REQ-034 en=0 after 2 of 4 samples, then en=1 with 4 samples of 100 -> dout=100 (partial sum discarded).
REQ-035 rst=1 during HOLD with dout_valid=1 -> next cycle dout=0, dout_valid=0, overrun=0, state IDLE.
